// File: rtl/bgnd_scroll_ctrl.sv
// rtl/bgnd_scroll_ctrl.sv - ground scroll sequencer: game state, scroll pulse, speed ramp, score
package bgnd_scroll_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_UNBEGIN = 2'b00,
    ST_RUNNING = 2'b01,
    ST_DEAD    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;
endpackage

module bgnd_scroll_ctrl
  import bgnd_scroll_ctrl_pkg::*;
#(
  parameter int CLK_DIV_INIT = 400000,
  parameter int CLK_DIV_MIN  = 100000,
  parameter int DIV_STEP     = 20000,
  parameter int RAMP_STEPS   = 1000,
  parameter int SCORE_STEPS  = 8,
  parameter int GNDW         = 2400,
  parameter int DEAD_HOLD    = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        collide,
  output logic [1:0]  gamestate,
  output logic        scroll_step,
  output logic [12:0] ground_pos,
  output logic [3:0]  speed_level,
  output logic [13:0] score
);
  localparam int RW = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
  localparam int SW = (SCORE_STEPS > 1) ? $clog2(SCORE_STEPS) : 1;
  localparam int HW = $clog2(DEAD_HOLD + 1);

  localparam logic [19:0]   DIV_INIT   = 20'(CLK_DIV_INIT);
  localparam logic [19:0]   DIV_MIN    = 20'(CLK_DIV_MIN);
  localparam logic [19:0]   DIV_DEC    = 20'(DIV_STEP);
  localparam logic [20:0]   DIV_THR    = 21'(CLK_DIV_MIN + DIV_STEP);
  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_STEPS - 1);
  localparam logic [SW-1:0] SCORE_LAST = SW'(SCORE_STEPS - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(DEAD_HOLD);
  localparam logic [12:0]   GND_LAST   = 13'(GNDW - 1);
  localparam logic [13:0]   SCORE_MAX  = 14'd9999;

  state_t        state, state_nxt;
  logic          btn_q;
  logic [19:0]   div_cnt, cur_div;
  logic [RW-1:0] ramp_cnt;
  logic [SW-1:0] score_cnt;
  logic [HW-1:0] hold_cnt;

  logic start_rise, step_due;
  logic do_step, do_tick, do_hold, do_clear;

  assign start_rise = start_btn & ~btn_q;
  assign step_due   = (div_cnt == cur_div - 20'd1);
  assign gamestate  = state;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_UNBEGIN;
    else     state <= state_nxt;
  end

  // Collision wins over a step that falls due on the same edge.
  always_comb begin
    state_nxt = state;
    do_step   = 1'b0;
    do_tick   = 1'b0;
    do_hold   = 1'b0;
    do_clear  = 1'b0;
    case (state)
      ST_UNBEGIN: begin
        do_clear = 1'b1;
        if (start_rise) state_nxt = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (collide)       state_nxt = ST_DEAD;
        else if (step_due) do_step   = 1'b1;
        else               do_tick   = 1'b1;
      end
      ST_DEAD: begin
        if (start_rise && hold_cnt == HOLD_MAX) begin
          state_nxt = ST_RUNNING;
          do_clear  = 1'b1;
        end else begin
          do_hold = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_UNBEGIN;
        do_clear  = 1'b1;
      end
    endcase
  end

  // btn_q follows the key even through reset so a held key never reads as a fresh press.
  always_ff @(posedge clk) begin
    btn_q <= start_btn;
  end

  always_ff @(posedge clk) begin
    if (rst || do_clear) begin
      scroll_step <= 1'b0;
      ground_pos  <= '0;
      speed_level <= '0;
      score       <= '0;
      div_cnt     <= '0;
      cur_div     <= DIV_INIT;
      ramp_cnt    <= '0;
      score_cnt   <= '0;
      hold_cnt    <= '0;
    end else begin
      scroll_step <= do_step;
      if (do_tick) div_cnt <= div_cnt + 20'd1;
      if (do_hold && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
      if (do_step) begin
        div_cnt    <= '0;
        ground_pos <= (ground_pos == GND_LAST) ? 13'd0 : ground_pos + 13'd1;
        if (ramp_cnt == RAMP_LAST) begin
          ramp_cnt <= '0;
          cur_div  <= ({1'b0, cur_div} >= DIV_THR) ? cur_div - DIV_DEC : DIV_MIN;
          if (speed_level != 4'hf) speed_level <= speed_level + 4'd1;
        end else begin
          ramp_cnt <= ramp_cnt + RW'(1);
        end
        if (score_cnt == SCORE_LAST) begin
          score_cnt <= '0;
          if (score < SCORE_MAX) score <= score + 14'd1;
        end else begin
          score_cnt <= score_cnt + SW'(1);
        end
      end
    end
  end
endmodule
